// File: rtl/cam_dvp_tx.sv
// Camera-side DVP transmitter: turns a valid/ready byte stream into vsync/href/data frames.
// Optional build macro CAM_DVP_TX_TEST_PATTERN_EN adds a col^row test pattern source.
module cam_dvp_tx #(
  parameter int unsigned LINE_BYTES = 320,
  parameter int unsigned LINES      = 120,
  parameter int unsigned VSYNC_LEN  = 8,
  parameter int unsigned VBP_LEN    = 16,
  parameter int unsigned HBLANK_LEN = 16,
  parameter int unsigned VFP_LEN    = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        clear_status,
`ifdef CAM_DVP_TX_TEST_PATTERN_EN
  input  logic        pattern_sel,
`endif
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_dat,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        underrun
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAX_LEN = max2(max2(max2(LINE_BYTES, VSYNC_LEN), max2(VBP_LEN, HBLANK_LEN)), VFP_LEN);
  localparam int unsigned CW      = $clog2(MAX_LEN + 1);
  localparam int unsigned LW      = $clog2(LINES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBP, S_LINE, S_HBLANK, S_VFP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n, len_m1;
  logic [LW-1:0] line, line_n;
  logic          cnt_last;
  logic          rdy_n;
  logic          fd_n;
  logic [7:0]    dat_n;

`ifdef CAM_DVP_TX_TEST_PATTERN_EN
  logic pat_q;
  logic pat_eff;

  // Pattern select is only taken at frame start so a frame is never mixed.
  assign pat_eff = (state == S_IDLE || state == S_VSYNC) ? pattern_sel : pat_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pat_q <= 1'b0;
    else         pat_q <= pat_eff;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      cnt   <= '0;
      line  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      line  <= line_n;
    end
  end

  // Next-state logic; every state's counter restarts at 0 on entry.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    line_n  = line;
    len_m1  = '0;
    case (state)
      S_VSYNC:  len_m1 = CW'(VSYNC_LEN - 1);
      S_VBP:    len_m1 = CW'(VBP_LEN - 1);
      S_LINE:   len_m1 = CW'(LINE_BYTES - 1);
      S_HBLANK: len_m1 = CW'(HBLANK_LEN - 1);
      S_VFP:    len_m1 = CW'(VFP_LEN - 1);
      default:  len_m1 = '0;
    endcase
    cnt_last = (cnt == len_m1);

    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (enable) state_n = S_VSYNC;
      end
      S_VSYNC: if (cnt_last) begin
        state_n = S_VBP;
        cnt_n   = '0;
      end
      S_VBP: if (cnt_last) begin
        state_n = S_LINE;
        cnt_n   = '0;
        line_n  = '0;
      end
      S_LINE: if (cnt_last) begin
        cnt_n = '0;
        if (line == LW'(LINES - 1)) begin
          state_n = S_VFP;
          line_n  = '0;
        end else begin
          state_n = S_HBLANK;
        end
      end
      S_HBLANK: if (cnt_last) begin
        state_n = S_LINE;
        cnt_n   = '0;
        line_n  = line + LW'(1);
      end
      S_VFP: if (cnt_last) begin
        cnt_n   = '0;
        state_n = enable ? S_VSYNC : S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        line_n  = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so every cam_* pin is a flop.
  always_comb begin
    rdy_n = ((state_n == S_VBP)    && (cnt_n == CW'(VBP_LEN - 1)))    ||
            ((state_n == S_HBLANK) && (cnt_n == CW'(HBLANK_LEN - 1))) ||
            ((state_n == S_LINE)   && (cnt_n <  CW'(LINE_BYTES - 1)));
    fd_n  = (state_n == S_VFP) && (cnt_n == CW'(VFP_LEN - 1));
    dat_n = 8'h00;
`ifdef CAM_DVP_TX_TEST_PATTERN_EN
    if (pat_eff) rdy_n = 1'b0;
    if (state_n == S_LINE) begin
      if (pat_eff)                dat_n = 8'(cnt_n) ^ 8'(line_n);
      else if (s_ready && s_valid) dat_n = s_data;
    end
`else
    if (state_n == S_LINE && s_ready && s_valid) dat_n = s_data;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_ready     <= 1'b0;
      cam_vsync   <= 1'b0;
      cam_href    <= 1'b0;
      cam_dat     <= 8'h00;
      frame_done  <= 1'b0;
      frame_count <= 16'h0000;
      underrun    <= 1'b0;
    end else begin
      s_ready    <= rdy_n;
      cam_vsync  <= (state_n == S_VSYNC);
      cam_href   <= (state_n == S_LINE);
      cam_dat    <= dat_n;
      frame_done <= fd_n;
      if (fd_n) frame_count <= frame_count + 16'd1;
      // A missed slot outranks a simultaneous clear.
      if (s_ready && !s_valid) underrun <= 1'b1;
      else if (clear_status)   underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cam_dvp_tx.sv
// Scoreboard bench for cam_dvp_tx: hand-computed byte sequences are queued per test and
// popped by a monitor on every href cycle; framing, timing and status are checked alongside.
module tb_cam_dvp_tx;

  localparam int LB = 4, NL = 2, VS = 2, VBP = 3, HB = 2, VFP = 2;
  localparam int FRAME = VS + VBP + NL * LB + (NL - 1) * HB + VFP;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        clear_status = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_dat;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        underrun;
`ifdef CAM_DVP_TX_TEST_PATTERN_EN
  logic        pattern_sel = 1'b0;
`endif

  int n_tests = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] src_q[$];
  int gap = -1, slot = 0, accepts = 0;
  int cyc = 0, href_cnt = 0, vs_cnt = 0, fd_cnt = 0, fd_cyc = 0;
  int vs_rises[$];
  logic prev_ready = 1'b0, prev_vs = 1'b0;
  bit pat_mode = 1'b0;

  cam_dvp_tx #(
    .LINE_BYTES(LB), .LINES(NL), .VSYNC_LEN(VS),
    .VBP_LEN(VBP), .HBLANK_LEN(HB), .VFP_LEN(VFP)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .clear_status(clear_status),
`ifdef CAM_DVP_TX_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .cam_vsync(cam_vsync),
    .cam_href(cam_href),
    .cam_dat(cam_dat),
    .frame_done(frame_done),
    .frame_count(frame_count),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Source driver: offers the head of src_q every cycle, skipping ready slot 'gap'.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (resetn && src_q.size() > 0 && slot != gap) begin
        s_valid = 1'b1;
        s_data  = src_q[0];
      end else begin
        s_valid = 1'b0;
        s_data  = 8'h00;
      end
      @(negedge clk);
      if (resetn && s_ready) begin
        slot++;
        if (s_valid && src_q.size() > 0) begin
          void'(src_q.pop_front());
          accepts++;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on href, checks idle data and ready/href alignment.
  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      prev_ready = 1'b0;
      prev_vs    = 1'b0;
    end else begin
      if (cam_vsync && !prev_vs) vs_rises.push_back(cyc);
      prev_vs = cam_vsync;
      if (cam_vsync) vs_cnt++;
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (cam_href) begin
        href_cnt++;
        if (exp_q.size() == 0) chk("dat_unexpected", int'(cam_dat), -1);
        else                   chk("cam_dat", int'(cam_dat), int'(exp_q.pop_front()));
      end else if (cam_dat != 8'h00) begin
        chk("dat_idle", int'(cam_dat), 0);
      end
      if (cam_vsync && cam_href) chk("vsync_href_overlap", 1, 0);
      if (pat_mode) begin
        if (s_ready) chk("pat_ready", int'(s_ready), 0);
      end else if (prev_ready != cam_href) begin
        chk("ready_align", int'(prev_ready), int'(cam_href));
      end
      prev_ready = s_ready;
    end
  end

  task automatic wait_fd(input int target, input string name);
    int n = 0;
    while (fd_cnt < target && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk(name, int'(fd_cnt >= target), 1);
    #1;
  endtask

  task automatic pulse_enable();
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vsync"},  int'(cam_vsync),   0);
    chk({tag, "_href"},   int'(cam_href),    0);
    chk({tag, "_dat"},    int'(cam_dat),     0);
    chk({tag, "_ready"},  int'(s_ready),     0);
    chk({tag, "_fdone"},  int'(frame_done),  0);
    chk({tag, "_fcount"}, int'(frame_count), 0);
    chk({tag, "_urun"},   int'(underrun),    0);
  endtask

  int b_acc, b_href, b_vs, b_fd, fc0, n;
  logic [7:0] line_v [8];

  initial begin
    repeat (3) @(posedge clk); #1;
    chk_all_zero("reset");
    resetn = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Test 1: single frame, bytes 0x10..0x17
    slot = 0; gap = -1;
    for (int i = 0; i < 8; i++) begin
      src_q.push_back(8'(8'h10 + i));
      exp_q.push_back(8'(8'h10 + i));
    end
    b_acc = accepts; b_href = href_cnt; b_vs = vs_cnt; b_fd = fd_cnt;
    pulse_enable();
    wait_fd(b_fd + 1, "t1_frame_done");
    chk("t1_fd_cycle", fd_cyc - vs_rises[vs_rises.size() - 1], FRAME - 1);
    repeat (10) @(posedge clk); #1;
    chk("t1_fd_once",   fd_cnt - b_fd, 1);
    chk("t1_vsync_len", vs_cnt - b_vs, VS);
    chk("t1_href_len",  href_cnt - b_href, 2 * LB);
    chk("t1_accepts",   accepts - b_acc, 8);
    chk("t1_fcount",    int'(frame_count), 1);
    chk("t1_exp_left",  exp_q.size(), 0);
    chk("t1_urun",      int'(underrun), 0);

    // Test 2: enable held for three back-to-back frames
    slot = 0;
    for (int i = 0; i < 24; i++) begin
      src_q.push_back(8'(8'h20 + i));
      exp_q.push_back(8'(8'h20 + i));
    end
    b_acc = accepts; b_vs = vs_cnt; b_fd = fd_cnt; fc0 = int'(frame_count);
    enable = 1'b1;
    wait_fd(b_fd + 2, "t2_frame2");
    enable = 1'b0;
    wait_fd(b_fd + 3, "t2_frame3");
    repeat (10) @(posedge clk); #1;
    n = vs_rises.size();
    chk("t2_period_a", vs_rises[n - 2] - vs_rises[n - 3], FRAME);
    chk("t2_period_b", vs_rises[n - 1] - vs_rises[n - 2], FRAME);
    chk("t2_fcount",   int'(frame_count), (fc0 + 3) & 16'hFFFF);
    chk("t2_vsync",    vs_cnt - b_vs, 3 * VS);
    chk("t2_accepts",  accepts - b_acc, 24);
    chk("t2_exp_left", exp_q.size(), 0);

    // Test 3: third ready slot starved -> zero byte and sticky underrun
    slot = 0; gap = 2;
    for (int i = 0; i < 7; i++) src_q.push_back(8'(8'h10 + i));
    line_v = '{8'h10, 8'h11, 8'h00, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    for (int i = 0; i < 8; i++) exp_q.push_back(line_v[i]);
    b_fd = fd_cnt;
    pulse_enable();
    wait_fd(b_fd + 1, "t3_frame_done");
    repeat (3) @(posedge clk); #1;
    gap = -1;
    chk("t3_urun_set",  int'(underrun), 1);
    chk("t3_exp_left",  exp_q.size(), 0);
    clear_status = 1'b1;
    @(posedge clk); #1;
    clear_status = 1'b0;
    chk("t3_urun_clr",  int'(underrun), 0);

    // Test 4: reset during line 1 aborts the frame; release with enable starts a fresh one
    slot = 0;
    for (int i = 0; i < 8; i++) begin
      src_q.push_back(8'(8'h40 + i));
      exp_q.push_back(8'(8'h40 + i));
    end
    b_href = href_cnt;
    enable = 1'b1;
    n = 0;
    while (href_cnt < b_href + 6 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("t4_reach_line1", int'(href_cnt >= b_href + 6), 1);
    #1;
    resetn = 1'b0;
    exp_q.delete();
    src_q.delete();
    b_fd = fd_cnt;
    #1;
    chk_all_zero("t4_reset");
    repeat (5) @(posedge clk); #1;
    chk("t4_no_fdone", fd_cnt - b_fd, 0);
    slot = 0;
    for (int i = 0; i < 8; i++) begin
      src_q.push_back(8'(8'h50 + i));
      exp_q.push_back(8'(8'h50 + i));
    end
    resetn = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    wait_fd(b_fd + 1, "t4_frame_done");
    chk("t4_fd_cycle",  fd_cyc - vs_rises[vs_rises.size() - 1], FRAME - 1);
    chk("t4_fcount",    int'(frame_count), 1);
    chk("t4_exp_left",  exp_q.size(), 0);
    repeat (4) @(posedge clk); #1;

    // Test 5: surplus bytes with s_valid held high; only the 8 ready slots consume
    slot = 0;
    for (int i = 0; i < 12; i++) src_q.push_back(8'(8'h60 + i));
    for (int i = 0; i < 8; i++)  exp_q.push_back(8'(8'h60 + i));
    b_acc = accepts; b_fd = fd_cnt;
    pulse_enable();
    wait_fd(b_fd + 1, "t5_frame_done");
    repeat (6) @(posedge clk); #1;
    chk("t5_accepts",  accepts - b_acc, 8);
    chk("t5_src_left", src_q.size(), 4);
    chk("t5_exp_left", exp_q.size(), 0);
    chk("t5_urun",     int'(underrun), 0);
    src_q.delete();

`ifdef CAM_DVP_TX_TEST_PATTERN_EN
    // Test 6: internal pattern, stream ignored
    repeat (2) @(posedge clk); #1;
    pattern_sel = 1'b1;
    pat_mode = 1'b1;
    for (int i = 0; i < 4; i++) src_q.push_back(8'hAA);
    line_v = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h01, 8'h00, 8'h03, 8'h02};
    for (int i = 0; i < 8; i++) exp_q.push_back(line_v[i]);
    b_acc = accepts; b_fd = fd_cnt;
    pulse_enable();
    wait_fd(b_fd + 1, "t6_frame_done");
    repeat (3) @(posedge clk); #1;
    chk("t6_accepts",  accepts - b_acc, 0);
    chk("t6_exp_left", exp_q.size(), 0);
    chk("t6_urun",     int'(underrun), 0);
    pattern_sel = 1'b0;
    pat_mode = 1'b0;
    src_q.delete();
`endif

    repeat (3) @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
